// File: rtl/note_inc_engine.sv
// Multi-channel MIDI note + pitch-bend to DDS phase increment engine (lookup, octave shift, shift-add interpolation).
// Optional key-off input req_gate is enabled by defining NOTE_INC_GATE_EN.
module note_inc_engine #(
    parameter int ACC_W  = 24,
    parameter int CH_NUM = 4,
    parameter int CH_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef NOTE_INC_GATE_EN
    input  logic                    req_gate,
`endif
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [6:0]              req_note,
    input  logic [13:0]             req_bend,
    output logic                    upd_valid,
    output logic [CH_W-1:0]         upd_ch,
    output logic [CH_NUM*ACC_W-1:0] inc_out
);

    localparam int PW = ACC_W + 14;

    typedef enum logic [2:0] {IDLE, LOOK0, LOOK1, MUL, WRITE} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch_q;
    logic [6:0]        note_q;
    logic [13:0]       bend_q;
    logic              key_off_q;
    logic [ACC_W-1:0]  inc0;
    logic              neg;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [13:0]       mplier;
    logic [3:0]        cnt;
    logic [ACC_W-1:0]  inc_r [CH_NUM];

    logic              key_off_in;
    logic [6:0]        nt;
    logic [13:0]       frac;
    logic [ACC_W-1:0]  inc_t_c;
    logic [ACC_W-1:0]  diff_c;
    logic [ACC_W-1:0]  scaled;
    logic [ACC_W-1:0]  inc_new;
    logic              ch_ok;

    function automatic logic [23:0] tbl(input logic [3:0] semi);
        case (semi)
            4'd0:    return 24'h0C18BC;
            4'd1:    return 24'h0CD0E1;
            4'd2:    return 24'h0D93F8;
            4'd3:    return 24'h0E62A9;
            4'd4:    return 24'h0F3DA5;
            4'd5:    return 24'h1025A6;
            4'd6:    return 24'h111B72;
            4'd7:    return 24'h121FDD;
            4'd8:    return 24'h1333C3;
            4'd9:    return 24'h145812;
            4'd10:   return 24'h158DC2;
            default: return 24'h16D5DC;
        endcase
    endfunction

    // Top-octave entry scaled to ACC_W, then shifted down to the note's octave.
    function automatic logic [ACC_W-1:0] lookup(input logic [6:0] n);
        logic [7:0]       m;
        logic [3:0]       oct;
        logic [3:0]       semi;
        logic [ACC_W-1:0] base;
        m    = {1'b0, n} + 8'd4;
        oct  = 4'(m / 8'd12);
        semi = 4'(m % 8'd12);
        base = ACC_W'(tbl(semi)) << (ACC_W - 24);
        return base >> (4'd10 - oct);
    endfunction

`ifdef NOTE_INC_GATE_EN
    assign key_off_in = ~req_gate;
`else
    assign key_off_in = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = key_off_in ? WRITE : LOOK0;
            end
            LOOK0:   state_nxt = LOOK1;
            LOOK1:   state_nxt = MUL;
            MUL:     if (cnt == 4'd13) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bend above centre aims two semitones up, below centre two down; frac = |bend - 8192|.
    always_comb begin
        nt   = note_q;
        frac = bend_q[13] ? {1'b0, bend_q[12:0]} : 14'd8192 - bend_q;
        if (bend_q[13] && (bend_q[12:0] != 13'd0))
            nt = (note_q > 7'd125) ? 7'd127 : note_q + 7'd2;
        else if (!bend_q[13])
            nt = (note_q < 7'd2) ? 7'd0 : note_q - 7'd2;
    end

    assign inc_t_c = lookup(nt);
    assign diff_c  = (inc_t_c >= inc0) ? inc_t_c - inc0 : inc0 - inc_t_c;
    assign scaled  = acc[ACC_W+12:13];
    assign inc_new = key_off_q ? '0 : (neg ? inc0 - scaled : inc0 + scaled);
    assign ch_ok   = {1'b0, ch_q} < (CH_W+1)'(CH_NUM);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q      <= '0;
            note_q    <= '0;
            bend_q    <= '0;
            key_off_q <= 1'b0;
            inc0      <= '0;
            neg       <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            upd_valid <= 1'b0;
            upd_ch    <= '0;
            // NOTE: the channel file is a handful of flops, so it is reset like any other register.
            for (int k = 0; k < CH_NUM; k++) inc_r[k] <= '0;
        end else begin
            upd_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    ch_q      <= req_ch;
                    note_q    <= req_note;
                    bend_q    <= req_bend;
                    key_off_q <= key_off_in;
                end
                LOOK0: inc0 <= lookup(note_q);
                LOOK1: begin
                    neg    <= inc_t_c < inc0;
                    mcand  <= PW'(diff_c);
                    mplier <= frac;
                    acc    <= '0;
                    cnt    <= '0;
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                WRITE: begin
                    upd_valid <= ch_ok;
                    if (ch_ok) upd_ch <= ch_q;
                    for (int k = 0; k < CH_NUM; k++)
                        if (ch_ok && ch_q == CH_W'(k)) inc_r[k] <= inc_new;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_flat
        assign inc_out[g*ACC_W +: ACC_W] = inc_r[g];
    end

endmodule

// File: tb/tb_note_inc_engine.sv
// Scoreboard bench for note_inc_engine: directed requests with hand-computed increments,
// a negedge monitor checks every upd_valid pulse against the expected-update queue.
module tb_note_inc_engine;

    localparam int ACC_W  = 24;
    localparam int CH_NUM = 4;
    localparam int CH_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [CH_W-1:0]         req_ch;
    logic [6:0]              req_note;
    logic [13:0]             req_bend;
    logic                    upd_valid;
    logic [CH_W-1:0]         upd_ch;
    logic [CH_NUM*ACC_W-1:0] inc_out;
`ifdef NOTE_INC_GATE_EN
    logic                    req_gate;
`endif

    note_inc_engine #(.ACC_W(ACC_W), .CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
        .clk(clk),
        .rst(rst),
`ifdef NOTE_INC_GATE_EN
        .req_gate(req_gate),
`endif
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_ch(req_ch),
        .req_note(req_note),
        .req_bend(req_bend),
        .upd_valid(upd_valid),
        .upd_ch(upd_ch),
        .inc_out(inc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] inc;
    } exp_t;

    exp_t             sbq[$];
    logic [ACC_W-1:0] model [CH_NUM];
    int               checks = 0;
    int               errors = 0;
    int               n_acc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] chan(input int k);
        return inc_out[k*ACC_W +: ACC_W];
    endfunction

    always @(posedge clk) if (!rst && req_valid && req_ready) n_acc++;

    always @(negedge clk) begin
        if (upd_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: got ch %0d expected no update", upd_ch);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("upd_ch", 64'(upd_ch), 64'(e.ch));
                check("upd_inc", 64'(chan(int'(e.ch))), 64'(e.inc));
            end
        end
    end

    task automatic check_all(input string tag);
        for (int k = 0; k < CH_NUM; k++)
            check($sformatf("%s_ch%0d", tag, k), 64'(chan(k)), 64'(model[k]));
    endtask

    task automatic scramble();
        req_ch   = CH_W'($urandom);
        req_note = 7'($urandom);
        req_bend = 14'($urandom);
    endtask

    // Issue one request from idle and follow it to completion.
    task automatic do_req(input logic [CH_W-1:0] ch, input logic [6:0] note,
                          input logic [13:0] bend, input logic gate,
                          input logic [ACC_W-1:0] exp_inc, input string tag);
        int   lat;
        logic wr;
        exp_t e;
        wr  = (int'(ch) < CH_NUM);
        lat = gate ? 17 : 1;
        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_ch    = ch;
        req_note  = note;
        req_bend  = bend;
`ifdef NOTE_INC_GATE_EN
        req_gate  = gate;
`endif
        if (wr) begin
            e.ch  = ch;
            e.inc = exp_inc;
            sbq.push_back(e);
            model[int'(ch)] = exp_inc;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
        repeat (lat - 1) @(negedge clk);
        check({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_early_upd"}, 64'(upd_valid), 64'd0);
        @(negedge clk);
        check({tag, "_upd_valid"}, 64'(upd_valid), 64'(wr));
        check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        check({tag, "_upd_pulse"}, 64'(upd_valid), 64'd0);
        check_all(tag);
    endtask

    initial begin
        int acc0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_ch    = '0;
        req_note  = '0;
        req_bend  = 14'd8192;
`ifdef NOTE_INC_GATE_EN
        req_gate  = 1'b1;
`endif
        for (int k = 0; k < CH_NUM; k++) model[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_upd_ch", 64'(upd_ch), 64'd0);
        check_all("rst");

        do_req(4'd0, 7'd69,  14'd8192,  1'b1, 24'h00CD0E, "a440");
        do_req(4'd1, 7'd69,  14'd12288, 1'b1, 24'h00D99C, "bend_up");
        do_req(4'd2, 7'd69,  14'd0,     1'b1, 24'h00B6AE, "bend_dn_full");
        do_req(4'd3, 7'd127, 14'd16383, 1'b1, 24'h16D5DC, "clamp_hi");
        do_req(4'd1, 7'd60,  14'd8192,  1'b1, 24'h0079ED, "note60");
        do_req(4'd2, 7'd0,   14'd0,     1'b1, 24'h0003CF, "clamp_lo");
        do_req(4'd3, 7'd0,   14'd8192,  1'b1, 24'h0003CF, "note0");
        do_req(4'd3, 7'd69,  14'd4096,  1'b1, 24'h00C1DE, "bend_dn_half");
        do_req(4'd1, 7'd69,  14'd8193,  1'b1, 24'h00CD0E, "frac_one");
        do_req(4'(CH_NUM), 7'd69, 14'd12288, 1'b1, 24'h0, "ch_oor");

        // req_valid held high: only accepts at E0 and E18; B's fields appear just before E18.
        begin
            exp_t e;
            acc0 = n_acc;
            @(negedge clk);
            req_valid = 1'b1;
            req_ch    = 4'd0;
            req_note  = 7'd60;
            req_bend  = 14'd8192;
            e.ch = 4'd0; e.inc = 24'h0079ED; sbq.push_back(e); model[0] = 24'h0079ED;
            e.ch = 4'd2; e.inc = 24'h16D5DC; sbq.push_back(e); model[2] = 24'h16D5DC;
            for (int i = 1; i <= 35; i++) begin
                @(negedge clk);
                if (i == 18) begin
                    req_ch   = 4'd2;
                    req_note = 7'd127;
                    req_bend = 14'd16383;
                end else begin
                    scramble();
                end
            end
            @(negedge clk);
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("b2b_accepts", 64'(n_acc - acc0), 64'd2);
            check_all("b2b");
        end

        // Reset eight cycles into a computation aborts it without a write.
        @(negedge clk);
        req_valid = 1'b1;
        req_ch    = 4'd1;
        req_note  = 7'd60;
        req_bend  = 14'd12288;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < CH_NUM; k++) model[k] = '0;
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_upd_valid", 64'(upd_valid), 64'd0);
        check("abort_upd_ch", 64'(upd_ch), 64'd0);
        check_all("abort");
        repeat (20) @(negedge clk);
        check_all("abort_quiet");

`ifdef NOTE_INC_GATE_EN
        do_req(4'd0, 7'd69, 14'd8192, 1'b1, 24'h00CD0E, "gate_on");
        do_req(4'd0, 7'd69, 14'd8192, 1'b0, 24'h000000, "key_off");
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_inc_engine.md
Name: note_inc_engine

Overview:
- Multi-channel successor to the combinational note-number-to-DDS-increment lookup.
- Holds one DDS phase increment per channel. Each increment is computed from a MIDI note number plus a 14-bit pitch bend of ±2 semitones, interpolated linearly.
- Uses a 12-entry top-octave table, octave shifting and a sequential shift-add multiplier.
- Sits between the MIDI parser and the per-channel DDS accumulators.

Parameters:
- ACC_W, 24, increment width; legal range 24..32. Table constants are left-shifted by ACC_W-24.
- CH_NUM, 4, number of channels; legal range 1..16.
- CH_W, 4, width of req_ch; must satisfy 2^CH_W >= CH_NUM.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  update request
- req_ready  out  1  engine idle, request accepted when valid&&ready
- req_ch  in  CH_W  target channel
- req_note  in  7  MIDI note 0..127
- req_bend  in  14  pitch bend, 8192 = centre
- upd_valid  out  1  one-cycle pulse when a channel register is written
- upd_ch  out  CH_W  channel written (valid with upd_valid)
- inc_out  out  CH_NUM*ACC_W  flattened per-channel increments; channel k occupies bits [k*ACC_W +: ACC_W]

Behaviour:
- Reset: req_ready=1, upd_valid=0, upd_ch=0, all inc_out=0, FSM=IDLE. Reset mid-computation aborts the operation; no write occurs.
- Table T[0..11], 24-bit, in order: 0C18BC, 0CD0E1, 0D93F8, 0E62A9, 0F3DA5, 1025A6, 111B72, 121FDD, 1333C3, 145812, 158DC2, 16D5DC.
- lookup(n):
  - m = n+4
  - oct = m/12 (0..10), semi = m%12
  - result = (T[semi] << (ACC_W-24)) >> (10-oct), truncated.
- Target note and fraction:
  - d = req_bend-8192, signed.
  - Target note nt = note+2 if d>0, note-2 if d<0, note if d=0. nt is clamped to 0..127.
  - frac = |d|, 14 bits, range 0..8192.
- Result: inc = inc0 ± ((|inc_t-inc0| * frac) >> 13).
  - Sign is + if inc_t>=inc0, else -.
  - Product is ACC_W+14 bits, truncated after the shift.
  - frac=8192 yields exactly inc_t.
- FSM: IDLE -> LOOK0 -> LOOK1 -> MUL -> WRITE -> IDLE.
  - IDLE: req_ready=1. On valid&&ready at edge E0, latch ch/note/bend, drop req_ready, go to LOOK0.
  - LOOK0: register inc0=lookup(note).
  - LOOK1: register inc_t=lookup(nt), abs diff and sign.
  - MUL: exactly 14 shift-add iterations over frac bits, LSB first. No early exit, even when frac=0.
  - WRITE: write channel register, assert upd_valid/upd_ch for one cycle, set req_ready=1.
- Latency: the new inc_out value and the upd_valid pulse are visible in the cycle after edge E17. Throughput is one request per 18 cycles.
- req_ch >= CH_NUM: the request is accepted and runs the full sequence, but no register is written and upd_valid stays 0.
- Inputs other than req_valid are ignored while req_ready=0.
- Channels not addressed by a request hold their value.

Optional Feature:
- Macro NOTE_INC_GATE_EN.
- Defined:
  - Adds input port req_gate (1 bit).
  - A request accepted with req_gate=0 is a key-off. The FSM goes straight to WRITE (skipping LOOK0/LOOK1/MUL), writes inc=0 to the channel and pulses upd_valid. The value is visible after edge E1, latency 2.
  - req_gate=1 behaves as the normal path.
- Undefined: no req_gate port. Every request follows the full 18-cycle path.

Test Plan:
- Reset, then idle -> req_ready=1, inc_out all 0, upd_valid=0.
- ch0, note 69, bend 8192 -> after 18 cycles ch0=0x00CD0E, upd_valid single pulse with upd_ch=0, req_ready high again. Note 60 gives 0x0079ED; note 0 gives 0x0003CF.
- ch1, note 69, bend 12288 -> ch1=0x00D99C. ch2, note 69, bend 0 -> ch2=0x00B6AE. ch0 unchanged at 0x00CD0E.
- Clamp: ch3, note 127, bend 16383 -> ch3=0x16D5DC. Note 0, bend 0 -> 0x0003CF.
- Protocol: req_valid held high continuously with varying data -> exactly one accept per 18 cycles; fields changed while busy have no effect. req_ch=CH_NUM -> no upd_valid, no register change. Assert rst at cycle 8 of a computation -> all outputs return to reset values and no write occurs.
- With NOTE_INC_GATE_EN: ch0 at 0x00CD0E, then req_gate=0 -> ch0=0 after 2 cycles, upd_valid pulse, req_ready=1.
